// File: rtl/uart_tx_arbiter_if.sv
// Byte-source and UART transmitter handshake bundle for the TX arbiter.
// slave = arbiter side, master = producers plus transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_int;
  logic                 tx_busy;

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_data, tx_int
  );

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_data, tx_int
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources, one frame per grant.
// Latency: req_ready is combinational in IDLE; tx_int rises the cycle after accept.
// Backpressure: req_ready stays low outside IDLE; pending requesters simply hold req_valid.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int START_TIMEOUT = 64,
  parameter int GAP_CYCLES    = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus,
  output logic [1:0]       grant_id,
  output logic             busy,
  output logic             timeout_err
);
  localparam int MAX_CNT = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_DONE, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      grant_q;
  logic [7:0]      tx_data_q;
  logic            timeout_q, timeout_d;
  logic            accept;
  logic            found;
  logic [1:0]      win;
  int              idx;

  // Scan starts one past the last grant so every requester gets its turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(grant_q) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = 2'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          accept  = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (bus.tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_GAP;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      grant_q   <= 2'(NUM_REQ - 1);
      tx_data_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (state_q == S_LAUNCH || state_q == S_GAP)
        cnt_q <= cnt_q + 1'b1;
      if (accept) begin
        tx_data_q <= bus.req_data[8*int'(win) +: 8];
        grant_q   <= win;
      end
    end
  end

  assign bus.req_ready = (accept && !rst) ? (NUM_REQ'(1) << win) : '0;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_int    = (state_q == S_LAUNCH);
  assign grant_id      = grant_q;
  assign busy          = (state_q != S_IDLE);
  assign timeout_err   = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: transmitter model, round-robin reference model and frame scoreboard.
module tb_uart_tx_arbiter;
  localparam int NR = 2;
  localparam int ST = 64;
  localparam int GC = 4;

  localparam int M_HOLD = 0;
  localparam int M_RAND = 1;
  localparam int M_BOTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .START_TIMEOUT(ST), .GAP_CYCLES(GC)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // requester and transmitter model state
  logic [NR-1:0] vld = '0;
  logic [NR-1:0] drop_next = '0;
  logic [NR-1:0] acc_last = '0;
  logic [7:0]    dat [NR];
  int            mode = M_HOLD;
  bit            tx_resp = 1'b1;
  bit            s1 = 0, s2 = 0, s3 = 0, last_int = 0;
  int            frame_left = 0;
  logic [7:0]    tx_cap = '0;

  // reference model state
  int            cyc = 0;
  int            m_phase = 0;
  int            m_last = NR - 1;
  int            m_free = 0;
  int            m_launch = 0;
  int            m_to_cyc = -1;
  logic [7:0]    m_byte = '0;
  logic [7:0]    expq [$];
  bit            skip_frame = 0;
  bit            prev_busy = 0;
  bit            prev_int = 0;
  bit            seen_rise = 0;
  int            low_run = 0;
  int            frames = 0;
  int            to_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  // Monitor / scoreboard: compares every cycle against the model, away from the active edge.
  always @(negedge clk) begin
    int         win;
    logic [NR-1:0] exp_ready;
    bit         idle;
    cyc++;
    if (prev_busy && !bus.tx_busy) begin
      if (skip_frame) skip_frame = 0;
      else if (expq.size() == 0) chk("frame_unexpected", 1, 0);
      else begin
        chk("frame_byte", tx_cap, expq.pop_front());
        frames++;
      end
    end
    prev_busy = bus.tx_busy;
    if (rst) begin
      m_phase = 0; m_last = NR - 1; m_free = 0; m_to_cyc = -1;
      expq.delete();
      if (bus.tx_busy) skip_frame = 1;
      acc_last = '0;
      prev_int = 0;
    end else begin
      if (bus.tx_int && !prev_int) begin
        if (seen_rise) chk("tx_int_low_gap", (low_run >= GC), 1);
        seen_rise = 1;
        low_run = 0;
      end else if (!bus.tx_int) low_run++;
      prev_int = bus.tx_int;
      if (timeout_err === 1'b1) to_seen++;

      idle = (m_phase == 0) && (cyc >= m_free);
      exp_ready = '0;
      win = -1;
      if (idle && |bus.req_valid) begin
        win = rr_pick(m_last, bus.req_valid);
        exp_ready[win] = 1'b1;
      end
      chk("req_ready", bus.req_ready, exp_ready);
      chk("busy", busy, !idle);
      chk("grant_id", grant_id, m_last);
      chk("tx_int", bus.tx_int, (m_phase == 1));
      chk("timeout_err", timeout_err, (cyc == m_to_cyc));
      if (m_phase != 0) chk("tx_data_stable", bus.tx_data, m_byte);
      acc_last = bus.req_ready & bus.req_valid;

      case (m_phase)
        0: if (win >= 0) begin
          m_last   = win;
          m_byte   = bus.req_data[8*win +: 8];
          expq.push_back(m_byte);
          m_phase  = 1;
          m_launch = cyc + 1;
        end
        1: if (bus.tx_busy) m_phase = 2;
           else if (cyc == m_launch + ST - 1) begin
             m_phase  = 0;
             m_to_cyc = cyc + 1;
             m_free   = cyc + 1 + GC;
             void'(expq.pop_back());
           end
        default: if (!bus.tx_busy) begin
          m_phase = 0;
          m_free  = cyc + 1 + GC;
        end
      endcase
    end
  end

  task automatic drive();
    bus.req_valid = vld;
    for (int i = 0; i < NR; i++) bus.req_data[8*i +: 8] = dat[i];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    s3 = s2; s2 = s1; s1 = last_int; last_int = bus.tx_int;
    if (frame_left > 0) begin
      frame_left--;
      bus.tx_busy = (frame_left != 0);
    end else if (tx_resp && s2 && !s3) begin
      bus.tx_busy = 1'b1;
      tx_cap      = bus.tx_data;
      frame_left  = $urandom_range(12, 30);
    end
    vld &= ~(acc_last | drop_next);
    drop_next = '0;
    if (mode == M_RAND) begin
      for (int i = 0; i < NR; i++) begin
        if (!vld[i] && $urandom_range(0, 3) == 0) begin
          vld[i] = 1'b1;
          dat[i] = 8'($urandom);
        end else if (vld[i] && $urandom_range(0, 15) == 0) vld[i] = 1'b0;
      end
    end else if (mode == M_BOTH) begin
      vld = '1;
      dat[0] = 8'hA5;
      dat[1] = 8'h5A;
    end
    drive();
  endtask

  task automatic offer(input int i, input logic [7:0] b);
    vld[i] = 1'b1;
    dat[i] = b;
    drive();
  endtask

  task automatic pulse(input int i, input logic [7:0] b);
    offer(i, b);
    drop_next[i] = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(m_phase == 0 && cyc + 1 >= m_free && !bus.tx_busy && frame_left == 0 && vld == '0)
           && n < 3000) begin
      step();
      n++;
    end
    chk({name, "_idle_timeout"}, (n < 3000), 1);
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    while (m_phase != 2 && n < 500) begin
      step();
      n++;
    end
    chk({name, "_wait_done_timeout"}, (n < 500), 1);
  endtask

  initial begin
    int f0;
    rst = 1'b1;
    bus.tx_busy = 1'b0;
    for (int i = 0; i < NR; i++) dat[i] = '0;
    drive();
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_tx_data", bus.tx_data, 8'h00);
    chk("reset_grant_id", grant_id, NR - 1);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", bus.req_ready, 0);
    chk("reset_timeout_err", timeout_err, 0);

    // single request
    offer(0, 8'h1C);
    wait_idle("single");
    chk("single_frames", frames, 1);

    // both valid continuously: strict alternation
    mode = M_BOTH;
    repeat (200) step();
    mode = M_HOLD;
    vld = '0;
    drive();
    wait_idle("both");

    // transmitter never responds: timeout and drop
    tx_resp = 1'b0;
    f0 = frames;
    offer(1, 8'h3C);
    wait_idle("timeout");
    tx_resp = 1'b1;
    chk("timeout_count", to_seen, 1);
    chk("timeout_byte_dropped", frames, f0);

    // reset during WAIT_DONE
    offer(1, 8'h77);
    wait_frame("reset");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_int", bus.tx_int, 0);
    chk("midrst_tx_data", bus.tx_data, 8'h00);
    chk("midrst_grant_id", grant_id, NR - 1);
    wait_idle("reset");
    offer(0, 8'h11);
    offer(1, 8'h22);
    step();
    chk("post_reset_first_grant", grant_id, 0);
    wait_idle("post_reset");

    // one-cycle pulse while busy is ignored; in IDLE it is taken once
    f0 = frames;
    offer(0, 8'hC3);
    wait_frame("pulse");
    pulse(1, 8'hE7);
    wait_idle("pulse_busy");
    chk("pulse_busy_frames", frames - f0, 1);
    pulse(1, 8'h9E);
    wait_idle("pulse_idle");
    chk("pulse_idle_frames", frames - f0, 2);

    // randomized back-to-back traffic
    mode = M_RAND;
    repeat (3000) step();
    mode = M_HOLD;
    vld = '0;
    drive();
    wait_idle("random");
    chk("scoreboard_empty", expq.size(), 0);
    chk("enough_frames", (frames >= 40), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end
endmodule
